decode_issue_queue: RTL

- Stage directly downstream of the dual-fetch unit.
- Captures up to two 16-bit instructions per cycle into a circular instruction queue and drops NOPs (16'h0000).
- Each cycle, issues one or two instructions to decode/execute from registered slots. Pairs are split when they have a register hazard or contain a branch.
- Drives backpressure to fetch and flushes on a taken branch.

---
 rtl/decode_issue_queue_if.sv | 31 +++
 rtl/decode_issue_queue.sv | 121 ++++++++++++
 2 files changed

// File: rtl/decode_issue_queue_if.sv
// Fetch-side and issue-side signal bundle of the decode issue queue.
// The queue itself takes the slave modport; the fetch/execute environment takes master.
interface decode_issue_queue_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [15:0]   instr1;
  logic [15:0]   instr2;
  logic          is_branch_taken;
  logic          issue_stall;
  logic          fetch_stall;
  logic [15:0]   issue0_instr;
  logic          issue0_valid;
  logic [15:0]   issue1_instr;
  logic          issue1_valid;
  logic [CW-1:0] count;
  logic          overflow_err;

  modport master (
    output instr1, instr2, is_branch_taken, issue_stall,
    input  fetch_stall, issue0_instr, issue0_valid, issue1_instr, issue1_valid,
           count, overflow_err
  );

  modport slave (
    input  instr1, instr2, is_branch_taken, issue_stall,
    output fetch_stall, issue0_instr, issue0_valid, issue1_instr, issue1_valid,
           count, overflow_err
  );
endinterface

// File: rtl/decode_issue_queue.sv
// Circular instruction queue between dual fetch and decode: drops NOPs,
// issues one or two instructions per cycle from registered slots, flushes on taken branch.
module decode_issue_queue #(
  parameter int         DEPTH     = 8,
  parameter int         SKID      = 4,
  parameter logic [3:0] BR_OPCODE = 4'hC
) (
  input logic                 clk,
  input logic                 reset_n,
  decode_issue_queue_if.slave dq
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [15:0]   mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   i0_q, i0_d, i1_q, i1_d;
  logic          v0_q, v0_d, v1_q, v1_d;

  logic          n1, n2, accept, pair_ok;
  logic [1:0]    k, n_iss;
  logic [CW-1:0] free;
  logic [PW-1:0] nxt_ptr;
  logic [15:0]   hd_instr, nx_instr;

  assign n1       = (dq.instr1 != 16'h0);
  assign n2       = (dq.instr2 != 16'h0);
  assign k        = {1'b0, n1} + {1'b0, n2};
  assign free     = CW'(DEPTH) - count_q;
  assign accept   = (free >= CW'(k));
  assign nxt_ptr  = head_q + PW'(1);
  assign hd_instr = mem_q[head_q];
  assign nx_instr = mem_q[nxt_ptr];

  // Dual issue only when neither is a branch and the second does not touch the first's rd.
  assign pair_ok = (count_q >= CW'(2))
                && (hd_instr[15:12] != BR_OPCODE)
                && (nx_instr[15:12] != BR_OPCODE)
                && (nx_instr[8:6]   != hd_instr[11:9])
                && (nx_instr[5:3]   != hd_instr[11:9])
                && (nx_instr[11:9]  != hd_instr[11:9]);

  always_comb begin
    n_iss = 2'd0;
    if (!dq.issue_stall && count_q != '0)
      n_iss = pair_ok ? 2'd2 : 2'd1;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    i0_d    = i0_q;
    i1_d    = i1_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    if (dq.is_branch_taken) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      i0_d    = 16'h0;
      i1_d    = 16'h0;
      v0_d    = 1'b0;
      v1_d    = 1'b0;
    end else begin
      if (accept)
        tail_d = tail_q + PW'(k);
      else
        ovf_d = 1'b1;
      if (!dq.issue_stall) begin
        v0_d = (count_q != '0);
        i0_d = (count_q != '0) ? hd_instr : 16'h0;
        v1_d = pair_ok;
        i1_d = pair_ok ? nx_instr : 16'h0;
      end
      head_d  = head_q + PW'(n_iss);
      count_d = count_q + (accept ? CW'(k) : CW'(0)) - CW'(n_iss);
    end
  end

  // Storage has no reset: entries are only read while count says they are live.
  always_ff @(posedge clk) begin
    if (reset_n && !dq.is_branch_taken && accept) begin
      if (n1) mem_q[tail_q] <= dq.instr1;
      if (n2) mem_q[tail_q + PW'(n1)] <= dq.instr2;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      i0_q    <= 16'h0;
      i1_q    <= 16'h0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      i0_q    <= i0_d;
      i1_q    <= i1_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
    end
  end

  assign dq.fetch_stall  = (free < CW'(SKID));
  assign dq.issue0_instr = i0_q;
  assign dq.issue0_valid = v0_q;
  assign dq.issue1_instr = i1_q;
  assign dq.issue1_valid = v1_q;
  assign dq.count        = count_q;
  assign dq.overflow_err = ovf_q;
endmodule
